// File: rtl/axis_packet_arbiter.sv
// Round-robin AXI-Stream packet arbiter with packet-granular lock.
// Forces release of a source that stalls mid-packet for IDLE_TIMEOUT cycles.
module axis_packet_arbiter #(
  parameter int NUM_PORTS    = 4,
  parameter int IDLE_TIMEOUT = 4096
) (
  input  logic                    axis_clk,
  input  logic                    axis_reset,
  input  logic [NUM_PORTS*32-1:0] s_axis_tdata,
  input  logic [NUM_PORTS*4-1:0]  s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]    s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]    s_axis_tlast,
  output logic [NUM_PORTS-1:0]    s_axis_tready,
  output logic [31:0]             m_axis_tdata,
  output logic [3:0]              m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic [NUM_PORTS-1:0]    grant,
  output logic [31:0]             pkt_count,
  output logic                    timeout_pulse
);

  localparam int LW = $clog2(NUM_PORTS);
  localparam int SW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic {IDLE, XFER} state_e;

  state_e               state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [LW-1:0]        last_q, last_d;
  logic [31:0]          pkt_q, pkt_d;
  logic [SW-1:0]        stall_q, stall_d;
  logic                 tmo_q, tmo_d;

  logic [31:0]   g_data;
  logic [3:0]    g_keep;
  logic          g_valid;
  logic          g_last;
  logic [LW-1:0] pick;
  logic          found;
  int            idx;

  always_comb begin
    g_data  = '0;
    g_keep  = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q[i]) begin
        g_data  = s_axis_tdata[32*i +: 32];
        g_keep  = s_axis_tkeep[4*i +: 4];
        g_valid = s_axis_tvalid[i];
        g_last  = s_axis_tlast[i];
      end
    end
  end

  // search starts one past the last winner and wraps
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && s_axis_tvalid[idx]) begin
        found = 1'b1;
        pick  = LW'(idx);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    pkt_d         = pkt_q;
    stall_d       = stall_q;
    tmo_d         = 1'b0;
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall_d = '0;
        if (found) begin
          state_d = XFER;
          grant_d = {{(NUM_PORTS-1){1'b0}}, 1'b1} << pick;
          last_d  = pick;
        end
      end
      XFER: begin
        m_axis_tdata  = g_data;
        m_axis_tkeep  = g_keep;
        m_axis_tvalid = g_valid;
        m_axis_tlast  = g_last;
        s_axis_tready = grant_q & {NUM_PORTS{m_axis_tready}};
        if (g_valid) begin
          stall_d = '0;
          if (m_axis_tready && g_last) begin
            state_d = IDLE;
            grant_d = '0;
            pkt_d   = pkt_q + 32'd1;
          end
        end else if (stall_q == SW'(IDLE_TIMEOUT - 1)) begin
          state_d = IDLE;
          grant_d = '0;
          stall_d = '0;
          tmo_d   = 1'b1;
        end else begin
          stall_d = stall_q + SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LW'(NUM_PORTS - 1);
      pkt_q   <= '0;
      stall_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      pkt_q   <= pkt_d;
      stall_q <= stall_d;
      tmo_q   <= tmo_d;
    end
  end

  assign grant         = grant_q;
  assign pkt_count     = pkt_q;
  assign timeout_pulse = tmo_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Bench for axis_packet_arbiter: per-port sources with a scoreboard
// of expected beats, plus grant/timeout traces per scenario.
module tb_axis_packet_arbiter;

  localparam int NP = 4;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           axis_reset;
  logic [NP*32-1:0] s_tdata;
  logic [NP*4-1:0]  s_tkeep;
  logic [NP-1:0]  s_tvalid;
  logic [NP-1:0]  s_tlast;
  logic [NP-1:0]  s_tready;
  logic [31:0]    m_tdata;
  logic [3:0]     m_tkeep;
  logic           m_tvalid;
  logic           m_tlast;
  logic           m_tready;
  logic [NP-1:0]  grant;
  logic [31:0]    pkt_count;
  logic           timeout_pulse;

  always #5 clk = ~clk;

  axis_packet_arbiter #(
    .NUM_PORTS(NP),
    .IDLE_TIMEOUT(TO)
  ) dut (
    .axis_clk     (clk),
    .axis_reset   (axis_reset),
    .s_axis_tdata (s_tdata),
    .s_axis_tkeep (s_tkeep),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tlast (s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tkeep (m_tkeep),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tlast (m_tlast),
    .m_axis_tready(m_tready),
    .grant        (grant),
    .pkt_count    (pkt_count),
    .timeout_pulse(timeout_pulse)
  );

  logic [36:0] src_q [NP][$];
  logic [36:0] exp_q [NP][$];
  logic [3:0]  glog [$];
  logic        tlog [$];
  int chk_cnt  = 0;
  int pass_cnt = 0;
  int xfer_cnt = 0;
  bit chk_rdy  = 0;
  bit tog_rdy  = 0;

  function automatic int idx_of(logic [NP-1:0] g);
    for (int i = 0; i < NP; i++)
      if (g[i]) return i;
    return -1;
  endfunction

  task automatic load_pkt(int p, int n, int id, bit close);
    logic [36:0] b;
    logic        l;
    logic [3:0]  k;
    for (int i = 0; i < n; i++) begin
      l = close && (i == n - 1);
      k = l ? 4'b0111 : 4'b1111;
      b = {l, k, 8'(p), 8'(id), 16'(i)};
      src_q[p].push_back(b);
      exp_q[p].push_back(b);
    end
  endtask

  task automatic drive();
    logic [36:0] b;
    for (int i = 0; i < NP; i++) begin
      if (src_q[i].size() > 0) begin
        b = src_q[i][0];
        s_tvalid[i]         = 1'b1;
        s_tdata[32*i +: 32] = b[31:0];
        s_tkeep[4*i +: 4]   = b[35:32];
        s_tlast[i]          = b[36];
      end else begin
        s_tvalid[i]         = 1'b0;
        s_tdata[32*i +: 32] = '0;
        s_tkeep[4*i +: 4]   = '0;
        s_tlast[i]          = 1'b0;
      end
    end
  endtask

  task automatic step();
    logic [NP-1:0] acc;
    logic [3:0]    er;
    logic [36:0]   e;
    int            p;
    @(negedge clk);
    glog.push_back(grant);
    tlog.push_back(timeout_pulse);
    if (chk_rdy) begin
      er = (grant == 4'b0010) ? {2'b00, m_tready, 1'b0} : 4'b0000;
      chk_cnt++;
      if (s_tready !== er)
        $display("FAIL s_tready got %b want %b", s_tready, er);
      else
        pass_cnt++;
    end
    acc = s_tready & s_tvalid;
    if (m_tvalid && m_tready) begin
      xfer_cnt++;
      p = idx_of(grant);
      chk_cnt++;
      if (p < 0 || exp_q[p].size() == 0) begin
        $display("FAIL sb_beat unexpected beat grant %b data %h",
                 grant, m_tdata);
      end else begin
        e = exp_q[p].pop_front();
        if ({m_tlast, m_tkeep, m_tdata} !== e)
          $display("FAIL sb_beat port%0d got %h want %h", p,
                   {m_tlast, m_tkeep, m_tdata}, e);
        else
          pass_cnt++;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++)
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    if (tog_rdy) m_tready = ~m_tready;
    drive();
  endtask

  task automatic flush();
    for (int i = 0; i < NP; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    drive();
  endtask

  task automatic do_reset();
    axis_reset = 1'b1;
    m_tready   = 1'b1;
    flush();
    @(posedge clk);
    @(posedge clk);
    #1;
    axis_reset = 1'b0;
    glog.delete();
    tlog.delete();
    xfer_cnt = 0;
  endtask

  task automatic test_reset();
    axis_reset = 1'b1;
    m_tready   = 1'b1;
    for (int i = 0; i < NP; i++) load_pkt(i, 2, 1, 1);
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if (grant !== 4'b0) $display("FAIL rst_grant got %b want 0", grant);
    else pass_cnt++;
    chk_cnt++;
    if (m_tvalid !== 1'b0) $display("FAIL rst_mvalid got %b want 0", m_tvalid);
    else pass_cnt++;
    chk_cnt++;
    if (s_tready !== 4'b0) $display("FAIL rst_sready got %b want 0", s_tready);
    else pass_cnt++;
    chk_cnt++;
    if (pkt_count !== 32'd0) $display("FAIL rst_pkt got %0d want 0", pkt_count);
    else pass_cnt++;
    chk_cnt++;
    if (timeout_pulse !== 1'b0)
      $display("FAIL rst_tmo got %b want 0", timeout_pulse);
    else pass_cnt++;
    do_reset();
  endtask

  task automatic test_two_ports();
    logic [3:0] eg [10] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0,
                            4'h4, 4'h4, 4'h4, 4'h0, 4'h0};
    do_reset();
    load_pkt(0, 3, 1, 1);
    load_pkt(2, 3, 1, 1);
    drive();
    repeat (10) step();
    for (int k = 0; k < 10; k++) begin
      chk_cnt++;
      if (glog[k] !== eg[k])
        $display("FAIL two_grant[%0d] got %h want %h", k, glog[k], eg[k]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (pkt_count !== 32'd2) $display("FAIL two_pkt got %0d want 2", pkt_count);
    else pass_cnt++;
    chk_cnt++;
    if (xfer_cnt != 6) $display("FAIL two_xfers got %0d want 6", xfer_cnt);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [3:0] eg [18] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4,
                            4'h0, 4'h8, 4'h0, 4'h1, 4'h0, 4'h2,
                            4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h0};
    do_reset();
    for (int i = 0; i < NP; i++) begin
      load_pkt(i, 1, 1, 1);
      load_pkt(i, 1, 2, 1);
    end
    drive();
    repeat (18) step();
    for (int k = 0; k < 18; k++) begin
      chk_cnt++;
      if (glog[k] !== eg[k])
        $display("FAIL rr_grant[%0d] got %h want %h", k, glog[k], eg[k]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (pkt_count !== 32'd8) $display("FAIL rr_pkt got %0d want 8", pkt_count);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset();
    load_pkt(1, 5, 3, 1);
    drive();
    chk_rdy = 1;
    tog_rdy = 1;
    repeat (16) step();
    chk_rdy  = 0;
    tog_rdy  = 0;
    m_tready = 1'b1;
    chk_cnt++;
    if (xfer_cnt != 5) $display("FAIL bp_xfers got %0d want 5", xfer_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (pkt_count !== 32'd1) $display("FAIL bp_pkt got %0d want 1", pkt_count);
    else pass_cnt++;
    chk_cnt++;
    if (exp_q[1].size() != 0)
      $display("FAIL bp_left got %0d want 0", exp_q[1].size());
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    logic [3:0] eg [13];
    logic       et [13];
    for (int k = 0; k < 13; k++) begin
      eg[k] = (k >= 1 && k <= 10) ? 4'h8 : 4'h0;
      et[k] = (k == 11);
    end
    do_reset();
    load_pkt(3, 2, 4, 0);
    drive();
    repeat (13) step();
    for (int k = 0; k < 13; k++) begin
      chk_cnt++;
      if (glog[k] !== eg[k])
        $display("FAIL to_grant[%0d] got %h want %h", k, glog[k], eg[k]);
      else pass_cnt++;
      chk_cnt++;
      if (tlog[k] !== et[k])
        $display("FAIL to_pulse[%0d] got %b want %b", k, tlog[k], et[k]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (pkt_count !== 32'd0) $display("FAIL to_pkt got %0d want 0", pkt_count);
    else pass_cnt++;
    chk_cnt++;
    if (xfer_cnt != 2) $display("FAIL to_xfers got %0d want 2", xfer_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_pkt(2, 4, 5, 1);
    drive();
    step();
    step();
    @(negedge clk);
    chk_cnt++;
    if (grant !== 4'h4 || m_tvalid !== 1'b1)
      $display("FAIL mid_beat2 got %h/%b want 4/1", grant, m_tvalid);
    else pass_cnt++;
    axis_reset = 1'b1;
    @(posedge clk);
    #1;
    flush();
    @(negedge clk);
    chk_cnt++;
    if (grant !== 4'h0) $display("FAIL mid_grant got %h want 0", grant);
    else pass_cnt++;
    chk_cnt++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0)
      $display("FAIL mid_mvalid got %b/%b want 0/0", m_tvalid, m_tlast);
    else pass_cnt++;
    chk_cnt++;
    if (pkt_count !== 32'd0) $display("FAIL mid_pkt got %0d want 0", pkt_count);
    else pass_cnt++;
    @(posedge clk);
    #1;
    axis_reset = 1'b0;
    glog.delete();
    load_pkt(2, 1, 6, 1);
    load_pkt(0, 1, 6, 1);
    drive();
    repeat (5) step();
    chk_cnt++;
    if (glog[1] !== 4'h1) $display("FAIL mid_first got %h want 1", glog[1]);
    else pass_cnt++;
    chk_cnt++;
    if (glog[3] !== 4'h4) $display("FAIL mid_second got %h want 4", glog[3]);
    else pass_cnt++;
  endtask

  initial begin
    axis_reset = 1'b1;
    m_tready   = 1'b1;
    s_tvalid   = '0;
    s_tdata    = '0;
    s_tkeep    = '0;
    s_tlast    = '0;
    test_reset();
    test_two_ports();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
